// File: rtl/dispenser_pkg.sv
// Shared definitions for the dispenser block family.
// Holds the controller state encoding, the default width of mL quantities
// and the largest volume the keypad stage can ever hand down to us.
package dispenser_pkg;

  localparam int DEFAULT_AMOUNT_WIDTH = 14;
  localparam int MAX_AMOUNT_ML        = 9999;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DISPENSING = 2'd1,
    ST_FAULT      = 2'd2
  } state_t;

endpackage

// File: rtl/flow_pulse_sync.sv
// Brings the raw flow-meter output into the clock domain and turns each
// rising edge into a single-cycle flow_edge strobe.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   flow_pulse    raw asynchronous flow-meter signal
//   flow_edge     1-cycle strobe, high the cycle after the synchronized
//                 signal first shows a 1 (SYNC_STAGES+1 clocks after the
//                 input edge, as seen by a consumer flop)
module flow_pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic flow_pulse,
  output logic flow_edge
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_prev;

  // Synchronizer chain plus one extra flop holding the previous synchronized
  // level, so the edge detector never looks at a metastable stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      sync_prev  <= 1'b0;
    end else begin
      sync_chain[0] <= flow_pulse;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
      sync_prev <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign flow_edge = sync_chain[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/dispense_controller.sv
// Dispense controller: accepts a confirmed volume, opens the valve, counts
// flow-meter pulses until the volume is delivered, then closes the valve and
// reports completion. A no-pulse timeout moves to FAULT; stop aborts a run.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   start          1-cycle request to dispense amount_ml (ignored if 0)
//   amount_ml      requested volume, sampled only on an accepted start
//   stop           1-cycle user abort
//   fault_clear    1-cycle fault acknowledge
//   flow_pulse     raw asynchronous flow-meter output
//   valve_open     registered valve drive
//   busy           high while dispensing
//   remaining_ml   volume still to deliver
//   dispensed_ml   volume delivered in the current/last run
//   done           1-cycle pulse at the end of a completed or aborted run
//   fault          high while in FAULT
module dispense_controller
  import dispenser_pkg::*;
#(
  parameter int          AMOUNT_WIDTH   = DEFAULT_AMOUNT_WIDTH,
  parameter int unsigned ML_PER_PULSE   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AMOUNT_WIDTH-1:0] amount_ml,
  input  logic                    stop,
  input  logic                    fault_clear,
  input  logic                    flow_pulse,
  output logic                    valve_open,
  output logic                    busy,
  output logic [AMOUNT_WIDTH-1:0] remaining_ml,
  output logic [AMOUNT_WIDTH-1:0] dispensed_ml,
  output logic                    done,
  output logic                    fault
);

  localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_WIDTH-1:0]  TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [AMOUNT_WIDTH:0]   ML_STEP    = (AMOUNT_WIDTH+1)'(ML_PER_PULSE);

  state_t                  state;
  state_t                  next_state;
  logic                    flow_edge;
  logic                    start_accept;
  logic [TIMER_WIDTH-1:0]  idle_timer;
  logic [AMOUNT_WIDTH:0]   dispensed_sum;
  logic [AMOUNT_WIDTH-1:0] remaining_sat;
  logic [AMOUNT_WIDTH-1:0] dispensed_sat;
  logic                    valve_next;
  logic                    done_next;

  flow_pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_flow_pulse_sync (
    .clock     (clock),
    .reset     (reset),
    .flow_pulse(flow_pulse),
    .flow_edge (flow_edge)
  );

  // Saturating counter updates; the extra bit on the sum catches overflow.
  assign start_accept  = (state == ST_IDLE) && start && (amount_ml != '0);
  assign dispensed_sum = {1'b0, dispensed_ml} + ML_STEP;
  assign dispensed_sat = dispensed_sum[AMOUNT_WIDTH] ? '1 : dispensed_sum[AMOUNT_WIDTH-1:0];
  assign remaining_sat = ({1'b0, remaining_ml} > ML_STEP) ?
                         (remaining_ml - ML_STEP[AMOUNT_WIDTH-1:0]) : '0;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A flow edge is counted before stop is honoured, and a
  // user stop takes precedence over a timeout landing in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_accept) next_state = ST_DISPENSING;
      end
      ST_DISPENSING: begin
        if (flow_edge && (remaining_sat == '0)) next_state = ST_IDLE;
        else if (stop)                          next_state = ST_IDLE;
        else if (!flow_edge && (idle_timer == TIMER_LAST)) next_state = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clear) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode. valve and done are precomputed from next_state so the
  // registered versions change on the same edge as the state itself; done
  // only fires for DISPENSING -> IDLE, never for a timeout.
  always_comb begin
    busy       = (state == ST_DISPENSING);
    fault      = (state == ST_FAULT);
    valve_next = (next_state == ST_DISPENSING);
    done_next  = (state == ST_DISPENSING) && (next_state == ST_IDLE);
  end

  // Registered outputs, volume counters and the no-pulse timer. The timer
  // stops at TIMER_LAST because the FSM leaves DISPENSING on that cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valve_open   <= 1'b0;
      done         <= 1'b0;
      remaining_ml <= '0;
      dispensed_ml <= '0;
      idle_timer   <= '0;
    end else begin
      valve_open <= valve_next;
      done       <= done_next;
      if (start_accept) begin
        remaining_ml <= amount_ml;
        dispensed_ml <= '0;
        idle_timer   <= '0;
      end else if (state == ST_DISPENSING) begin
        if (flow_edge) begin
          remaining_ml <= remaining_sat;
          dispensed_ml <= dispensed_sat;
          idle_timer   <= '0;
        end else if (idle_timer != TIMER_LAST) begin
          idle_timer <= idle_timer + TIMER_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dispense_controller.sv
// Self-checking bench for dispense_controller. Two instances (1 and 2 mL per
// pulse) share one stimulus stream; each is compared every cycle against its
// own behavioural model, followed by a randomized phase.
module tb_dispense_controller;
  import dispenser_pkg::*;

  localparam int W    = 14;
  localparam int T    = 100;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_DISP  = 1;
  localparam int MODE_FAULT = 2;

  typedef struct {
    int mode;
    int remaining;
    int dispensed;
    int quiet_cycles;
    bit done;
  } model_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] amount_ml;
  logic         stop;
  logic         fault_clear;
  logic         flow_pulse;

  logic         valve_open   [2];
  logic         busy         [2];
  logic [W-1:0] remaining_ml [2];
  logic [W-1:0] dispensed_ml [2];
  logic         done         [2];
  logic         fault        [2];

  model_t model        [2];
  int     ml_per_pulse [2] = '{1, 2};
  int     done_count   [2] = '{0, 0};
  bit     pulse_hist   [$];
  int     compared   = 0;
  int     mismatched = 0;

  always #5 clock = ~clock;

  dispense_controller #(
    .AMOUNT_WIDTH(W), .ML_PER_PULSE(1), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)
  ) dut_ml1 (
    .clock(clock), .reset(reset), .start(start), .amount_ml(amount_ml),
    .stop(stop), .fault_clear(fault_clear), .flow_pulse(flow_pulse),
    .valve_open(valve_open[0]), .busy(busy[0]), .remaining_ml(remaining_ml[0]),
    .dispensed_ml(dispensed_ml[0]), .done(done[0]), .fault(fault[0])
  );

  dispense_controller #(
    .AMOUNT_WIDTH(W), .ML_PER_PULSE(2), .TIMEOUT_CYCLES(T), .SYNC_STAGES(S)
  ) dut_ml2 (
    .clock(clock), .reset(reset), .start(start), .amount_ml(amount_ml),
    .stop(stop), .fault_clear(fault_clear), .flow_pulse(flow_pulse),
    .valve_open(valve_open[1]), .busy(busy[1]), .remaining_ml(remaining_ml[1]),
    .dispensed_ml(dispensed_ml[1]), .done(done[1]), .fault(fault[1])
  );

  // Single point of comparison: counts and reports.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock of the controller's rules applied to the model.
  function automatic model_t stepModel(model_t m, int ml, bit edge_seen, bit st, int amt,
                                       bit sp, bit fc);
    m.done = 1'b0;
    case (m.mode)
      MODE_IDLE: begin
        if (st && amt != 0) begin
          m.mode = MODE_DISP; m.remaining = amt; m.dispensed = 0; m.quiet_cycles = 0;
        end
      end
      MODE_DISP: begin
        if (edge_seen) begin
          m.remaining    = (m.remaining > ml) ? m.remaining - ml : 0;
          m.dispensed    = (m.dispensed + ml > MAXV) ? MAXV : m.dispensed + ml;
          m.quiet_cycles = 0;
          if (m.remaining == 0 || sp) begin m.mode = MODE_IDLE; m.done = 1'b1; end
        end else if (sp) begin
          m.mode = MODE_IDLE; m.done = 1'b1;
        end else if (m.quiet_cycles == T - 1) begin
          m.mode = MODE_FAULT;
        end else begin
          m.quiet_cycles++;
        end
      end
      default: begin
        if (fc) m.mode = MODE_IDLE;
      end
    endcase
    return m;
  endfunction

  task automatic resetModel();
    for (int d = 0; d < 2; d++) model[d] = '{MODE_IDLE, 0, 0, 0, 1'b0};
    pulse_hist.delete();
    repeat (S + 1) pulse_hist.push_back(1'b0);
  endtask

  task automatic checkAll(input string phase);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s valve%0d", phase, d), valve_open[d], model[d].mode == MODE_DISP);
      checkOutput($sformatf("%s busy%0d", phase, d), busy[d], model[d].mode == MODE_DISP);
      checkOutput($sformatf("%s fault%0d", phase, d), fault[d], model[d].mode == MODE_FAULT);
      checkOutput($sformatf("%s done%0d", phase, d), done[d], model[d].done);
      checkOutput($sformatf("%s remaining%0d", phase, d), remaining_ml[d], model[d].remaining);
      checkOutput($sformatf("%s dispensed%0d", phase, d), dispensed_ml[d], model[d].dispensed);
      if (done[d] === 1'b1) done_count[d]++;
    end
  endtask

  // Drive one clock of inputs, advance the models, check 1 time unit later.
  task automatic applyStimulus(input bit st, input int amt, input bit sp, input bit fc,
                               input bit fp);
    int n;
    bit edge_seen;
    @(negedge clock);
    start = st; amount_ml = W'(amt); stop = sp; fault_clear = fc; flow_pulse = fp;
    @(posedge clock);
    pulse_hist.push_back(fp);
    n = pulse_hist.size();
    edge_seen = pulse_hist[n-1-S] && !pulse_hist[n-2-S];
    while (pulse_hist.size() > S + 2) void'(pulse_hist.pop_front());
    for (int d = 0; d < 2; d++)
      model[d] = stepModel(model[d], ml_per_pulse[d], edge_seen, st, amt, sp, fc);
    #1;
    checkAll("cyc");
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, $urandom_range(0, 20), 0, 0, 0);
  endtask

  task automatic sendPulses(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int rate;
    reset = 1'b1; start = 0; amount_ml = '0; stop = 0; fault_clear = 0; flow_pulse = 0;
    resetModel();
    #1;
    checkAll("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Normal run of 3 mL; the 2 mL/pulse instance saturates at 0 and ends early.
    applyStimulus(1, 3, 0, 0, 0);
    checkOutput("run3 valve after start", valve_open[0], 1);
    sendPulses(3);
    idleCycles(3);
    checkOutput("run3 dispensed", dispensed_ml[0], 3);
    checkOutput("run3 remaining", remaining_ml[0], 0);
    checkOutput("run3 done count", done_count[0], 1);
    checkOutput("ml2 dispensed", dispensed_ml[1], 4);
    checkOutput("ml2 done count", done_count[1], 1);

    // Zero amount is ignored.
    applyStimulus(1, 0, 0, 0, 0);
    idleCycles(3);
    checkOutput("zero amount valve", valve_open[0], 0);
    checkOutput("zero amount done count", done_count[0], 1);

    // Abort after 2 pulses keeps partial counts.
    applyStimulus(1, 5, 0, 0, 0);
    sendPulses(2);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("abort done", done[0], 1);
    checkOutput("abort remaining", remaining_ml[0], 3);
    checkOutput("abort dispensed", dispensed_ml[0], 2);
    idleCycles(2);

    // No-pulse timeout, then clear and restart.
    applyStimulus(1, 5, 0, 0, 0);
    sendPulses(1);
    idleCycles(T + 5);
    checkOutput("timeout fault", fault[0], 1);
    checkOutput("timeout valve", valve_open[0], 0);
    applyStimulus(1, 7, 0, 0, 0);
    checkOutput("start ignored in fault", fault[0], 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("fault cleared", fault[0], 0);
    applyStimulus(1, 2, 0, 0, 0);
    checkOutput("restart valve", valve_open[0], 1);
    sendPulses(2);
    idleCycles(2);

    // Asynchronous reset mid-dispense.
    applyStimulus(1, 4, 0, 0, 0);
    sendPulses(2);
    #2 reset = 1'b1;
    resetModel();
    #1;
    checkOutput("async reset valve", valve_open[0], 0);
    checkAll("async reset");
    @(negedge clock);
    reset = 1'b0;
    idleCycles(2);

    // Randomized phase: alternating pulse-rich and silent stretches.
    for (int blk = 0; blk < 6; blk++) begin
      rate = (blk % 3 == 2) ? 0 : 1;
      for (int i = 0; i < 120; i++) begin
        applyStimulus($urandom_range(0, 14) == 0,
                      ($urandom_range(0, 9) == 0) ? MAX_AMOUNT_ML : $urandom_range(0, 12),
                      $urandom_range(0, 49) == 0,
                      $urandom_range(0, 9) == 0,
                      (rate != 0) ? bit'($urandom_range(0, 1)) : 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
